// File: rtl/pc_sequencer.sv
// Program-counter stage: owns the architectural PC, sequences a run from
// Start to Halt, applies relative branches and keeps a small return stack.
module pc_sequencer #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [D-1:0] StartAddr,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic [D-1:0] Target,
    input  logic         Call,
    input  logic         Ret,
    input  logic         Halt,
    output logic [D-1:0] ProgCtr,
    output logic         Fetch,
    output logic         Done,
    output logic         StackErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [SW-1:0]  sp_q, sp_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic [D-1:0]   stack_q [DEPTH];

    logic           push_en;
    logic [D-1:0]   pc_inc;
    logic [D-1:0]   pc_rel;
    logic           stack_empty;
    logic           stack_full;
    logic [AW-1:0]  top_idx;
    logic [AW-1:0]  push_idx;

    // Target arrives already sign-extended, so a plain D-bit add wraps correctly.
    assign pc_inc      = pc_q + D'(1);
    assign pc_rel      = pc_q + Target;
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SW'(DEPTH));
    assign top_idx     = sp_q[AW-1:0] - AW'(1);
    assign push_idx    = sp_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        done_d  = done_q;
        push_en = 1'b0;

        if (Start) begin
            state_d = S_RUN;
            pc_d    = StartAddr;
            sp_d    = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            if (Stall) begin
                pc_d = pc_q;
            end else if (Halt) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else if (Ret) begin
                if (stack_empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d = stack_q[top_idx];
                    sp_d = sp_q - SW'(1);
                end
            end else if (Call) begin
                pc_d = pc_rel;
                if (stack_full) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SW'(1);
                end
            end else if (BranchEn) begin
                pc_d = pc_rel;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign ProgCtr  = pc_q;
    assign Fetch    = (state_q == S_RUN);
    assign Done     = done_q;
    assign StackErr = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [11:0] StartAddr;
    logic        Stall;
    logic        BranchEn;
    logic [11:0] Target;
    logic        Call;
    logic        Ret;
    logic        Halt;
    logic [11:0] ProgCtr;
    logic        Fetch;
    logic        Done;
    logic        StackErr;

    int checks;
    int failures;

    pc_sequencer #(.D(12), .DEPTH(4)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .StartAddr(StartAddr),
        .Stall    (Stall),
        .BranchEn (BranchEn),
        .Target   (Target),
        .Call     (Call),
        .Ret      (Ret),
        .Halt     (Halt),
        .ProgCtr  (ProgCtr),
        .Fetch    (Fetch),
        .Done     (Done),
        .StackErr (StackErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_in();
        Start     = 1'b0;
        StartAddr = '0;
        Stall     = 1'b0;
        BranchEn  = 1'b0;
        Target    = '0;
        Call      = 1'b0;
        Ret       = 1'b0;
        Halt      = 1'b0;
    endtask

    // one rising edge, then settle on the falling edge
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic start_at(input logic [11:0] a);
        clear_in();
        Start     = 1'b1;
        StartAddr = a;
        step();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        Reset_n = 1'b0;
        #12;
        checks++;
        if (ProgCtr !== 12'h000 || Fetch !== 1'b0 || Done !== 1'b0 ||
            StackErr !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals pc=%h fetch=%b done=%b err=%b req 000/0/0/0",
                     ProgCtr, Fetch, Done, StackErr);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        BranchEn = 1'b1;
        Target   = 12'h005;
        Call     = 1'b1;
        step();
        step();
        checks++;
        if (ProgCtr !== 12'h000 || Fetch !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore pc=%h fetch=%b req 000/0", ProgCtr, Fetch);
        end
        clear_in();
    endtask

    task automatic test_sequential();
        logic [11:0] exp_pc;
        start_at(12'h010);
        checks++;
        if (ProgCtr !== 12'h010 || Fetch !== 1'b1) begin
            failures++;
            $display("FAIL start_pc pc=%h fetch=%b req 010/1", ProgCtr, Fetch);
        end
        exp_pc = 12'h010;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 12'h001;
            checks++;
            if (ProgCtr !== exp_pc || Fetch !== 1'b1) begin
                failures++;
                $display("FAIL seq_inc%0d pc=%h fetch=%b req %h/1",
                         i, ProgCtr, Fetch, exp_pc);
            end
        end
    endtask

    task automatic test_branch();
        start_at(12'h06A);
        BranchEn = 1'b1;
        Target   = 12'hF97;
        step();
        checks++;
        if (ProgCtr !== 12'h001) begin
            failures++;
            $display("FAIL branch_neg pc=%h req 001", ProgCtr);
        end
        start_at(12'hFFE);
        BranchEn = 1'b1;
        Target   = 12'h009;
        step();
        checks++;
        if (ProgCtr !== 12'h007) begin
            failures++;
            $display("FAIL branch_wrap pc=%h req 007", ProgCtr);
        end
        Target = 12'h000;
        step();
        checks++;
        if (ProgCtr !== 12'h007) begin
            failures++;
            $display("FAIL branch_zero pc=%h req 007", ProgCtr);
        end
        clear_in();
    endtask

    task automatic test_call_ret();
        start_at(12'h020);
        Call   = 1'b1;
        Target = 12'h00E;
        step();
        checks++;
        if (ProgCtr !== 12'h02E) begin
            failures++;
            $display("FAIL call_pc pc=%h req 02E", ProgCtr);
        end
        Call = 1'b0;
        Ret  = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 12'h021 || StackErr !== 1'b0) begin
            failures++;
            $display("FAIL ret_pc pc=%h err=%b req 021/0", ProgCtr, StackErr);
        end
        step();
        checks++;
        if (ProgCtr !== 12'h022 || StackErr !== 1'b1) begin
            failures++;
            $display("FAIL ret_empty pc=%h err=%b req 022/1", ProgCtr, StackErr);
        end
        Ret = 1'b0;
        step();
        checks++;
        if (ProgCtr !== 12'h023 || StackErr !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky pc=%h err=%b req 023/1", ProgCtr, StackErr);
        end
        start_at(12'h030);
        checks++;
        if (StackErr !== 1'b0) begin
            failures++;
            $display("FAIL start_clr_err err=%b req 0", StackErr);
        end
        Call   = 1'b1;
        Target = 12'h010;
        step();
        Ret = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 12'h031 || StackErr !== 1'b0) begin
            failures++;
            $display("FAIL ret_over_call pc=%h err=%b req 031/0", ProgCtr, StackErr);
        end
        Call = 1'b0;
        step();
        checks++;
        if (ProgCtr !== 12'h032 || StackErr !== 1'b1) begin
            failures++;
            $display("FAIL call_not_pushed pc=%h err=%b req 032/1", ProgCtr, StackErr);
        end
        clear_in();
    endtask

    task automatic test_overflow();
        logic [11:0] exp_call [5];
        logic [11:0] exp_ret  [4];
        exp_call = '{12'h110, 12'h120, 12'h130, 12'h140, 12'h150};
        exp_ret  = '{12'h131, 12'h121, 12'h111, 12'h101};
        start_at(12'h100);
        Call   = 1'b1;
        Target = 12'h010;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (ProgCtr !== exp_call[i] || StackErr !== (i == 4)) begin
                failures++;
                $display("FAIL call%0d pc=%h err=%b req %h/%b",
                         i, ProgCtr, StackErr, exp_call[i], (i == 4));
            end
        end
        Call = 1'b0;
        Ret  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ProgCtr !== exp_ret[i] || StackErr !== 1'b1) begin
                failures++;
                $display("FAIL pop%0d pc=%h err=%b req %h/1",
                         i, ProgCtr, StackErr, exp_ret[i]);
            end
        end
        step();
        checks++;
        if (ProgCtr !== 12'h102) begin
            failures++;
            $display("FAIL pop_empty pc=%h req 102", ProgCtr);
        end
        clear_in();
    endtask

    task automatic test_stall_halt();
        start_at(12'h03E);
        Stall    = 1'b1;
        BranchEn = 1'b1;
        Target   = 12'h050;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ProgCtr !== 12'h03E || Fetch !== 1'b1) begin
                failures++;
                $display("FAIL stall%0d pc=%h fetch=%b req 03E/1", i, ProgCtr, Fetch);
            end
        end
        clear_in();
        step();
        step();
        Halt = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 12'h040 || Done !== 1'b1 || Fetch !== 1'b0) begin
            failures++;
            $display("FAIL halt pc=%h done=%b fetch=%b req 040/1/0",
                     ProgCtr, Done, Fetch);
        end
        Halt     = 1'b0;
        BranchEn = 1'b1;
        Target   = 12'h005;
        step();
        checks++;
        if (ProgCtr !== 12'h040 || Done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold pc=%h done=%b req 040/1", ProgCtr, Done);
        end
        clear_in();
        Start     = 1'b1;
        StartAddr = 12'h000;
        Halt      = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 12'h000 || Done !== 1'b0 || Fetch !== 1'b1) begin
            failures++;
            $display("FAIL restart pc=%h done=%b fetch=%b req 000/0/1",
                     ProgCtr, Done, Fetch);
        end
        clear_in();
    endtask

    task automatic test_async_reset();
        start_at(12'h200);
        Ret = 1'b1;
        step();
        checks++;
        if (StackErr !== 1'b1 || ProgCtr !== 12'h201) begin
            failures++;
            $display("FAIL pre_rst pc=%h err=%b req 201/1", ProgCtr, StackErr);
        end
        Ret = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (ProgCtr !== 12'h000 || Fetch !== 1'b0 || Done !== 1'b0 ||
            StackErr !== 1'b0) begin
            failures++;
            $display("FAIL async_rst pc=%h fetch=%b done=%b err=%b req 000/0/0/0",
                     ProgCtr, Fetch, Done, StackErr);
        end
        #1;
        Reset_n  = 1'b1;
        BranchEn = 1'b1;
        Target   = 12'h033;
        Halt     = 1'b1;
        step();
        step();
        checks++;
        if (ProgCtr !== 12'h000 || Fetch !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_idle pc=%h fetch=%b done=%b req 000/0/0",
                     ProgCtr, Fetch, Done);
        end
        start_at(12'h055);
        checks++;
        if (ProgCtr !== 12'h055 || Fetch !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_start pc=%h fetch=%b req 055/1", ProgCtr, Fetch);
        end
        clear_in();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset_n  = 1'b1;
        clear_in();
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
